// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload expiry.
// Optional: define TC_MODE1_EN to implement auto-reload mode 1.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        enable;
    logic        im;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_n;
    logic        irq_r;
    logic        irq_n;
    logic        en_clr;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        freeze;
    logic        reload;
    logic        unused;

    assign unused    = ^{Addr[31:4], Addr[1:0]};
    assign ctrl_wr   = WE && (Addr[3:2] == 2'b00);
    assign preset_wr = WE && (Addr[3:2] == 2'b01);
    // Register writes stall the timer for that edge
    assign freeze    = ctrl_wr || preset_wr;
    assign IRQ       = im & irq_r;

`ifdef TC_MODE1_EN
    assign reload = (mode == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= 2'b00;
        end else if (ctrl_wr) begin
            mode <= Din[2:1];
        end
    end
`else
    assign reload = 1'b0;
    assign mode   = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            im     <= 1'b0;
            preset <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= Din[0];
                im     <= Din[3];
            end else if (en_clr) begin
                enable <= 1'b0;
            end
            if (preset_wr) begin
                preset <= Din;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            irq_r <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            irq_r <= irq_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        irq_n   = irq_r;
        en_clr  = 1'b0;
        if (freeze) begin
            irq_n = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state_n = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_n = preset;
                    state_n = S_CNT;
                end
                S_CNT: begin
                    if (!enable) begin
                        state_n = S_IDLE;
                    end else if (count > 32'd1) begin
                        count_n = count - 32'd1;
                    end else begin
                        count_n = '0;
                        irq_n   = 1'b1;
                        state_n = S_INT;
                    end
                end
                S_INT: begin
                    state_n = S_IDLE;
                    if (reload) begin
                        irq_n = 1'b0;
                    end else begin
                        en_clr = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = '0;
        unique case (Addr[3:2])
            2'b00:   Dout = {28'b0, im, mode, enable};
            2'b01:   Dout = preset;
            2'b10:   Dout = count;
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed table, corner sequences
// and randomized register traffic against a behavioural timer model.
module tb_timer_counter;

`ifdef TC_MODE1_EN
    localparam bit M1 = 1'b1;
`else
    localparam bit M1 = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_cmp;
    int n_bad;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: what the timer is doing, not how it is encoded
    logic        m_en;
    logic        m_im;
    logic [1:0]  m_mode;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_irq;
    bit          m_loading;
    bit          m_counting;
    bit          m_expired;

    task automatic model_reset();
        m_en = 0; m_im = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_irq = 0;
        m_loading = 0; m_counting = 0; m_expired = 0;
    endtask

    task automatic model_step(input logic we, input logic [31:0] a,
                              input logic [31:0] d);
        if (we && a[3:2] == 2'd0) begin
            m_en = d[0];
            m_im = d[3];
            m_mode = M1 ? d[2:1] : 2'b00;
            m_irq = 0;
        end else if (we && a[3:2] == 2'd1) begin
            m_preset = d;
            m_irq = 0;
        end else if (m_expired) begin
            m_expired = 0;
            if (m_mode == 2'b01) m_irq = 0;
            else m_en = 0;
        end else if (m_loading) begin
            m_loading = 0;
            m_counting = 1;
            m_count = m_preset;
        end else if (m_counting) begin
            if (!m_en) begin
                m_counting = 0;
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_count = 0;
                m_irq = 1;
                m_counting = 0;
                m_expired = 1;
            end
        end else if (m_en) begin
            m_loading = 1;
        end
    endtask

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0: return {28'b0, m_im, m_mode, m_en};
            1: return m_preset;
            2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rd(input int r, output logic [31:0] v);
        logic [31:0] up;
        up = $urandom;
        Addr = (up & 32'hFFFF_FFF0) | (r << 2) | (up & 32'h3);
        #1;
        v = Dout;
    endtask

    task automatic check_model();
        logic [31:0] v;
        for (int r = 0; r < 4; r++) begin
            rd(r, v);
            chk($sformatf("model_reg%0d", r), v, model_read(r));
        end
        chk("model_irq", {31'b0, IRQ}, {31'b0, m_im & m_irq});
    endtask

    task automatic cycle(input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        WE = we; Addr = a; Din = d;
        @(posedge clk);
        model_step(we, a, d);
        #1;
        WE = 0;
        #1;
    endtask

    task automatic nop();
        cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        reset = 0;
        model_reset();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ctrl;
        logic [31:0] cnt;
        logic        irq;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] v;
        logic        exp_irq;
        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{1, 32'h4, 32'd3, 32'h0, 32'd0, 0};
        tbl[1] = '{1, 32'h0, 32'h9, 32'h9, 32'd0, 0};
        tbl[2] = '{0, 32'h0, 32'h0, 32'h9, 32'd0, 0};
        tbl[3] = '{0, 32'h0, 32'h0, 32'h9, 32'd3, 0};
        tbl[4] = '{0, 32'h0, 32'h0, 32'h9, 32'd2, 0};
        tbl[5] = '{0, 32'h0, 32'h0, 32'h9, 32'd1, 0};
        tbl[6] = '{0, 32'h0, 32'h0, 32'h9, 32'd0, 1};
        tbl[7] = '{0, 32'h0, 32'h0, 32'h8, 32'd0, 1};
        tbl[8] = '{0, 32'h0, 32'h0, 32'h8, 32'd0, 1};
        tbl[9] = '{1, 32'h0, 32'h8, 32'h8, 32'd0, 0};

        reset = 1; WE = 0; Addr = 0; Din = 0;
        model_reset();
        #15;
        reset = 0;

        for (int r = 0; r < 4; r++) begin
            Addr = r << 2;
            #1;
            chk($sformatf("reset_reg%0d", r), Dout, 32'd0);
        end
        chk("reset_irq", {31'b0, IRQ}, 32'd0);

        // One-shot mode 0 walk-through
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].we, tbl[i].a, tbl[i].d);
            rd(0, v);
            chk($sformatf("tbl%0d_ctrl", i), v, tbl[i].ctrl);
            rd(2, v);
            chk($sformatf("tbl%0d_count", i), v, tbl[i].cnt);
            chk($sformatf("tbl%0d_irq", i), {31'b0, IRQ}, {31'b0, tbl[i].irq});
        end

        // Auto-reload: pulses at E5, E11, E17 (or one held expiry)
        do_reset();
        cycle(1, 32'h4, 32'd3);
        cycle(1, 32'h0, 32'hB);
        for (int e = 1; e <= 18; e++) begin
            nop();
            exp_irq = M1 ? (e == 5 || e == 11 || e == 17) : (e >= 5);
            chk($sformatf("mode1_irq_E%0d", e), {31'b0, IRQ}, {31'b0, exp_irq});
        end
        rd(0, v);
        chk("mode1_ctrl", v, M1 ? 32'hB : 32'h8);

        // PRESET 0 and 1 both expire at E3; IM=0 masks the request
        for (int p = 0; p < 2; p++) begin
            for (int m = 0; m < 2; m++) begin
                do_reset();
                cycle(1, 32'h4, p);
                cycle(1, 32'h0, m ? 32'h1 : 32'h9);
                nop();
                nop();
                chk($sformatf("p%0d_m%0d_irq_E2", p, m), {31'b0, IRQ}, 32'd0);
                nop();
                chk($sformatf("p%0d_m%0d_irq_E3", p, m), {31'b0, IRQ},
                    m ? 32'd0 : 32'd1);
                rd(2, v);
                chk($sformatf("p%0d_m%0d_count_E3", p, m), v, 32'd0);
            end
        end

        // Freeze mid-count, ignored COUNT write, reload on re-enable
        do_reset();
        cycle(1, 32'h4, 32'd10);
        cycle(1, 32'h0, 32'h1);
        for (int e = 1; e <= 7; e++) nop();
        rd(2, v);
        chk("mid_count5", v, 32'd5);
        cycle(1, 32'h0, 32'h0);
        nop();
        nop();
        rd(2, v);
        chk("mid_frozen", v, 32'd5);
        cycle(1, 32'h8, 32'hFFFF);
        rd(2, v);
        chk("mid_count_wr_ignored", v, 32'd5);
        cycle(1, 32'h0, 32'h1);
        nop();
        rd(2, v);
        chk("mid_before_reload", v, 32'd5);
        nop();
        rd(2, v);
        chk("mid_reloaded", v, 32'd10);
        check_model();

        // Asynchronous reset while the request is up
        do_reset();
        cycle(1, 32'h4, 32'd0);
        cycle(1, 32'h0, 32'h9);
        for (int e = 1; e <= 3; e++) nop();
        chk("areset_irq_before", {31'b0, IRQ}, 32'd1);
        #5;
        reset = 1;
        #1;
        chk("areset_irq", {31'b0, IRQ}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            Addr = r << 2;
            #1;
            chk($sformatf("areset_reg%0d", r), Dout, 32'd0);
        end
        reset = 0;
        model_reset();

        // Randomized register traffic against the model
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          r;
            logic        we;
            we = ($urandom_range(0, 9) < 2);
            r = $urandom_range(0, 3);
            a = ($urandom & 32'hFFFF_FFF0) | (r << 2) | ($urandom & 32'h3);
            case (r)
                0: d = ($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 15)
                       | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                1: d = $urandom_range(0, 6);
                default: d = $urandom;
            endcase
            cycle(we, a, d);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
